freq_gate_ctrl: RTL and testbench

- Gate-time sequencer for the 6-digit BCD frequency counter, which is clocked by F_IN and controlled by ENA/CLR.
- Runs on the system reference clock and repeats a fixed cycle: clear the counter, open ENA for a precise gate window, let the counter settle, latch its 24-bit BCD result into a display register, then hold.
- Supports single-shot and continuous modes, plus four decade gate ranges, with a decimal-point indication for the display.

---
 rtl/freq_gate_ctrl.sv | 163 ++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl
// Gate-time sequencer for a 6-digit BCD frequency counter. Runs on the
// reference clock and cycles CLEAR -> GATE -> SETTLE -> LATCH -> HOLD, then
// either returns to IDLE (single-shot) or re-enters CLEAR (continuous).
//
// Ports:
//   CLK    reference clock, rising edge
//   RST    asynchronous active-high reset
//   START  level, sampled in IDLE to begin a measurement
//   CONT   1 = continuous, 0 = single-shot (sampled at HOLD expiry)
//   RANGE  gate select: GATE_CYCLES / 10^RANGE (minimum 1)
//   CNT    24-bit BCD count from the F_IN-domain counter
//   ENA    counter enable (GATE only)
//   CLR    counter clear (CLEAR only)
//   LATCH  one-cycle strobe coincident with DISP update
//   DISP   latched BCD result
//   DP     range that produced DISP (decimal-point position)
//   BUSY   high in every state except IDLE
//   VALID  sticky, set on first LATCH
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES   = 50000000,
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 25000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CONT,
    input  logic [1:0]  RANGE,
    input  logic [23:0] CNT,
    output logic        ENA,
    output logic        CLR,
    output logic        LATCH,
    output logic [23:0] DISP,
    output logic [1:0]  DP,
    output logic        BUSY,
    output logic        VALID
);

    // Zero-valued parameters are illegal; treat them as 1.
    localparam int unsigned GATE_N   = (GATE_CYCLES   == 0) ? 1 : GATE_CYCLES;
    localparam int unsigned CLR_N    = (CLR_CYCLES    == 0) ? 1 : CLR_CYCLES;
    localparam int unsigned SETTLE_N = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned HOLD_N   = (HOLD_CYCLES   == 0) ? 1 : HOLD_CYCLES;

    // Decade gate lengths, floored at one cycle.
    localparam int unsigned GL0 = GATE_N;
    localparam int unsigned GL1 = (GATE_N / 10   == 0) ? 1 : GATE_N / 10;
    localparam int unsigned GL2 = (GATE_N / 100  == 0) ? 1 : GATE_N / 100;
    localparam int unsigned GL3 = (GATE_N / 1000 == 0) ? 1 : GATE_N / 1000;

    localparam int unsigned MAX_A = (GATE_N > HOLD_N) ? GATE_N : HOLD_N;
    localparam int unsigned MAX_B = (CLR_N > SETTLE_N) ? CLR_N : SETTLE_N;
    localparam int unsigned MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // Timer holds (duration - 1), so it needs to represent MAX_N-1.
    localparam int TW = (MAX_N < 2) ? 1 : $clog2(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LATCH, S_HOLD
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [TW-1:0]   gate_ld;
    logic [1:0]      range_q;

    always_comb begin
        gate_ld = TW'(GL0 - 1);
        case (range_q)
            2'd0:    gate_ld = TW'(GL0 - 1);
            2'd1:    gate_ld = TW'(GL1 - 1);
            2'd2:    gate_ld = TW'(GL2 - 1);
            default: gate_ld = TW'(GL3 - 1);
        endcase
    end

    // Each state runs for (load + 1) cycles and exits when the timer is 0;
    // the timer is reloaded on the transition into the next state.
    always_comb begin
        state_n = state;
        timer_n = (timer != '0) ? timer - TW'(1) : timer;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_n = S_CLEAR;
                    timer_n = TW'(CLR_N - 1);
                end
            end
            S_CLEAR: begin
                if (timer == '0) begin
                    state_n = S_GATE;
                    timer_n = gate_ld;
                end
            end
            S_GATE: begin
                if (timer == '0) begin
                    state_n = S_SETTLE;
                    timer_n = TW'(SETTLE_N - 1);
                end
            end
            S_SETTLE: begin
                if (timer == '0) begin
                    state_n = S_LATCH;
                    timer_n = '0;
                end
            end
            S_LATCH: begin
                state_n = S_HOLD;
                timer_n = TW'(HOLD_N - 1);
            end
            S_HOLD: begin
                if (timer == '0) begin
                    if (CONT) begin
                        state_n = S_CLEAR;
                        timer_n = TW'(CLR_N - 1);
                    end else begin
                        state_n = S_IDLE;
                        timer_n = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // line toward the F_IN domain comes straight from a flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            timer   <= '0;
            range_q <= 2'd0;
            ENA     <= 1'b0;
            CLR     <= 1'b0;
            LATCH   <= 1'b0;
            DISP    <= 24'd0;
            DP      <= 2'd0;
            BUSY    <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            ENA   <= (state_n == S_GATE);
            CLR   <= (state_n == S_CLEAR);
            LATCH <= (state_n == S_LATCH);
            BUSY  <= (state_n != S_IDLE);
            // Range is frozen on CLEAR entry; later RANGE moves are ignored.
            if (state_n == S_CLEAR && state != S_CLEAR)
                range_q <= RANGE;
            // CNT is sampled at the end of SETTLE, when the counter is static.
            if (state_n == S_LATCH) begin
                DISP  <= CNT;
                DP    <= range_q;
                VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        CONT = 1'b0;
    logic [1:0]  RANGE = 2'd0;
    logic [23:0] CNT = 24'd0;
    logic        ENA, CLR, LATCH, BUSY, VALID;
    logic [23:0] DISP;
    logic [1:0]  DP;

    int n_cmp = 0;
    int n_err = 0;

    freq_gate_ctrl #(
        .GATE_CYCLES(1000), .CLR_CYCLES(4), .SETTLE_CYCLES(4), .HOLD_CYCLES(20)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .CONT(CONT), .RANGE(RANGE),
        .CNT(CNT), .ENA(ENA), .CLR(CLR), .LATCH(LATCH), .DISP(DISP),
        .DP(DP), .BUSY(BUSY), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and check
    // that ENA and CLR are never high together.
    task automatic tick();
        @(posedge CLK);
        #1;
        chk("ena_clr_excl", 32'(ENA & CLR), 0);
    endtask

    // One measurement cycle, returning the measured widths.
    task automatic run_meas(input bit do_start, input bit keep_start,
                            input bit chg_rng, input logic [1:0] rng_mid,
                            input bit cont_mid, input bit poke_start,
                            input logic [23:0] exp_disp, input logic [1:0] exp_dp,
                            output int cw, output int ew, output int gw, output int hw);
        bit extra;
        if (do_start) begin
            START = 1'b1;
            tick();
            if (!keep_start) START = 1'b0;
        end
        chk("clr_rise", 32'(CLR), 1);
        cw = 0;
        while (CLR && cw < 100) begin cw++; tick(); end
        chk("gate_direct", 32'(ENA), 1);
        ew = 0;
        while (ENA && ew < 5000) begin
            ew++;
            if (chg_rng && ew == 1) RANGE = rng_mid;
            if (poke_start && ew == 3) START = 1'b1;
            if (poke_start && ew == 4) START = 1'b0;
            tick();
        end
        gw = 0;
        while (!LATCH && gw < 100) begin gw++; tick(); end
        chk("latch_strobe", 32'(LATCH), 1);
        chk("disp", 32'(DISP), 32'(exp_disp));
        chk("dp", 32'(DP), 32'(exp_dp));
        chk("valid", 32'(VALID), 1);
        tick();
        chk("latch_one_cycle", 32'(LATCH), 0);
        extra = 1'b0;
        hw = 0;
        while (BUSY && !CLR && hw < 100) begin
            hw++;
            extra = extra | LATCH;
            if (hw == 2) CNT = CNT ^ 24'h111111;
            if (cont_mid && hw == 5) CONT = 1'b0;
            if (poke_start && hw == 3) START = 1'b1;
            if (poke_start && hw == 4) START = 1'b0;
            tick();
        end
        chk("no_extra_latch", 32'(extra), 0);
        chk("disp_hold_stable", 32'(DISP), 32'(exp_disp));
    endtask

    initial begin
        int cw, ew, gw, hw, k;

        // Reset state
        tick(); tick();
        chk("rst_ena", 32'(ENA), 0);
        chk("rst_clr", 32'(CLR), 0);
        chk("rst_latch", 32'(LATCH), 0);
        chk("rst_disp", 32'(DISP), 0);
        chk("rst_dp", 32'(DP), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_valid", 32'(VALID), 0);
        RST = 1'b0;
        tick();
        chk("idle_busy", 32'(BUSY), 0);

        // Reset in the middle of GATE
        START = 1'b1;
        tick();
        START = 1'b0;
        k = 0;
        while (!ENA && k < 50) begin k++; tick(); end
        chk("midgate_ena_up", 32'(ENA), 1);
        for (int i = 0; i < 300; i++) tick();
        RST = 1'b1;
        #1;
        chk("midgate_rst_ena", 32'(ENA), 0);
        chk("midgate_rst_busy", 32'(BUSY), 0);
        chk("midgate_rst_valid", 32'(VALID), 0);
        chk("midgate_rst_disp", 32'(DISP), 0);
        tick();
        RST = 1'b0;
        tick();

        // Single-shot, RANGE=0
        CNT = 24'h001234;
        run_meas(1, 0, 0, 2'd0, 0, 0, 24'h001234, 2'd0, cw, ew, gw, hw);
        chk("r0_clr_w", 32'(cw), 4);
        chk("r0_ena_w", 32'(ew), 1000);
        chk("r0_settle_w", 32'(gw), 4);
        chk("r0_hold_w", 32'(hw), 20);
        chk("r0_idle_busy", 32'(BUSY), 0);
        tick();
        chk("r0_no_restart", 32'(BUSY), 0);

        // RANGE=3 -> single-cycle gate
        RANGE = 2'd3;
        CNT = 24'h000007;
        run_meas(1, 0, 0, 2'd0, 0, 0, 24'h000007, 2'd3, cw, ew, gw, hw);
        chk("r3_ena_w", 32'(ew), 1);
        chk("r3_hold_w", 32'(hw), 20);

        // RANGE=2, changed to 0 during GATE: width and DP keep the captured value
        RANGE = 2'd2;
        CNT = 24'h000055;
        run_meas(1, 0, 1, 2'd0, 0, 0, 24'h000055, 2'd2, cw, ew, gw, hw);
        chk("r2_ena_w", 32'(ew), 10);
        chk("r2_settle_w", 32'(gw), 4);

        // Continuous: CLR re-asserts after the hold
        CONT = 1'b1;
        RANGE = 2'd3;
        CNT = 24'h000100;
        run_meas(1, 0, 0, 2'd0, 0, 0, 24'h000100, 2'd3, cw, ew, gw, hw);
        chk("cont_hold_w", 32'(hw), 20);
        chk("cont_reclear", 32'(CLR), 1);
        chk("cont_busy", 32'(BUSY), 1);
        CNT = 24'h000200;
        run_meas(0, 0, 0, 2'd0, 1, 0, 24'h000200, 2'd3, cw, ew, gw, hw);
        chk("cont2_clr_w", 32'(cw), 4);
        chk("cont2_hold_w", 32'(hw), 20);
        chk("cont2_idle", 32'(BUSY), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("cont2_no_clr", 32'(CLR), 0);
        chk("cont2_stay_idle", 32'(BUSY), 0);

        // START pulses during GATE and HOLD are ignored
        RANGE = 2'd1;
        CNT = 24'h012345;
        run_meas(1, 0, 0, 2'd0, 0, 1, 24'h012345, 2'd1, cw, ew, gw, hw);
        chk("poke_ena_w", 32'(ew), 100);
        chk("poke_hold_w", 32'(hw), 20);
        chk("poke_idle", 32'(BUSY), 0);

        // START held high with CONT=0 retriggers right after IDLE re-entry
        RANGE = 2'd3;
        CNT = 24'h000777;
        run_meas(1, 1, 0, 2'd0, 0, 0, 24'h000777, 2'd3, cw, ew, gw, hw);
        chk("retrig_idle", 32'(BUSY), 0);
        tick();
        chk("retrig_clr", 32'(CLR), 1);
        START = 1'b0;
        CNT = 24'h000321;
        run_meas(0, 0, 0, 2'd0, 0, 0, 24'h000321, 2'd3, cw, ew, gw, hw);
        chk("retrig_clr_w", 32'(cw), 4);
        chk("retrig_idle2", 32'(BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
